// File: rtl/mmul_pkg.sv
// mmul_pkg: shared constants and types for the shared-multiplier sequencer.
//   MMUL_OP_W    : Q8.8 operand width ([15:8] integer, [7:0] fraction)
//   MMUL_RES_W   : Q16.16 product width
//   MMUL_TIMEOUT : default number of RUN cycles before an operation is aborted
//   state_e      : sequencer state encoding (IDLE/CLR/RUN/DONE)
package mmul_pkg;

  localparam int MMUL_OP_W    = 32'd16;
  localparam int MMUL_RES_W   = 32'd32;
  localparam int MMUL_TIMEOUT = 32'd64;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLR  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CLR  = ST_CLR,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
//   req  : request vector, bit N from requester N
//   last : index of the requester granted most recently
//   gnt  : one-hot grant (all zero when nobody requests)
// A lone requester always wins; under contention the requester that was not
// granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Grant selection from the request pattern and the last-grant pointer.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: shares one bmul Q8.8 x Q8.8 -> Q16.16 multiplier between two
// requesters. Arbitrates round-robin, owns the multiplier rst/in_rdy handshake,
// returns the product to the winner and aborts a hung multiplier after TIMEOUT
// RUN cycles.
//   clk, rst              : clock (rising edge), asynchronous active-high reset
//   reqN, op_aN, op_bN    : requester N request and operands (held until ackN)
//   ackN                  : one-cycle pulse, requester N operands captured
//   doneN                 : one-cycle pulse, res/err valid for requester N
//   res, err              : last product (held until next done), timeout flag
//   busy                  : high in every state except IDLE
//   m_rst, m_a, m_b,
//   m_in_rdy              : drive the multiplier
//   m_res, m_res_rdy      : multiplier result and result-ready
// Every output comes straight from a flop, so each *_d value below is what the
// output shows during the state being entered.
module mul_share_ctrl
  import mmul_pkg::*;
#(
  parameter int OP_W    = MMUL_OP_W,
  parameter int RES_W   = MMUL_RES_W,
  parameter int TIMEOUT = MMUL_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [OP_W-1:0]  op_a0,
  input  logic [OP_W-1:0]  op_b0,
  output logic             ack0,
  output logic             done0,
  input  logic             req1,
  input  logic [OP_W-1:0]  op_a1,
  input  logic [OP_W-1:0]  op_b1,
  output logic             ack1,
  output logic             done1,
  output logic [RES_W-1:0] res,
  output logic             err,
  output logic             busy,
  output logic             m_rst,
  output logic [OP_W-1:0]  m_a,
  output logic [OP_W-1:0]  m_b,
  output logic             m_in_rdy,
  input  logic [RES_W-1:0] m_res,
  input  logic             m_res_rdy
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;       // last granted requester
  logic               win_q, win_d;       // requester being served
  logic [CNT_W-1:0]   cnt_q, cnt_d;       // RUN cycles elapsed
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               done0_q, done0_d;
  logic               done1_q, done1_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic [OP_W-1:0]    m_a_q, m_a_d;
  logic [OP_W-1:0]    m_b_q, m_b_d;
  logic               m_in_rdy_q, m_in_rdy_d;
  logic               m_rst_q, m_rst_d;
  logic [1:0]         gnt_s;

  rr_arb2 u_arb (
    .req  ({req1, req0}),
    .last (ptr_q),
    .gnt  (gnt_s)
  );

  // Next-state and next-output logic for the IDLE/CLR/RUN/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    err_d      = err_q;
    busy_d     = busy_q;
    res_d      = res_q;
    m_a_d      = m_a_q;
    m_b_d      = m_b_q;
    m_in_rdy_d = 1'b0;
    m_rst_d    = 1'b0;
    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (gnt_s != 2'b00) begin
          win_d   = gnt_s[1];
          m_a_d   = gnt_s[1] ? op_a1 : op_a0;
          m_b_d   = gnt_s[1] ? op_b1 : op_b0;
          ack0_d  = gnt_s[0];
          ack1_d  = gnt_s[1];
          // Pulse the multiplier reset to clear any stale res_rdy.
          m_rst_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = CLR;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      CLR: begin
        m_in_rdy_d = 1'b1;
        cnt_d      = '0;
        state_d    = RUN;
      end
      RUN: begin
        if (m_res_rdy) begin
          res_d   = m_res;
          err_d   = 1'b0;
          done0_d = ~win_q;
          done1_d = win_q;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Watchdog expired: report an error and hold the multiplier in reset.
          res_d   = '0;
          err_d   = 1'b1;
          done0_d = ~win_q;
          done1_d = win_q;
          m_rst_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d      = cnt_q + CNT_W'(1);
          m_in_rdy_d = 1'b1;
          state_d    = RUN;
        end
      end
      DONE: begin
        ptr_d   = win_q;
        busy_d  = 1'b0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered-output flops; reset leaves requester 0 with priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b1;
      win_q      <= 1'b0;
      cnt_q      <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      res_q      <= '0;
      m_a_q      <= '0;
      m_b_q      <= '0;
      m_in_rdy_q <= 1'b0;
      m_rst_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      res_q      <= res_d;
      m_a_q      <= m_a_d;
      m_b_q      <= m_b_d;
      m_in_rdy_q <= m_in_rdy_d;
      m_rst_q    <= m_rst_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign res      = res_q;
  assign m_a      = m_a_q;
  assign m_b      = m_b_q;
  assign m_in_rdy = m_in_rdy_q;
  assign m_rst    = m_rst_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Self-checking bench for mul_share_ctrl with a behavioural bmul model.
module tb_mul_share_ctrl;

  localparam int TO  = 16;   // DUT watchdog length
  localparam int LAT = 5;    // model: in_rdy cycles before res_rdy rises

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] op_a0 = 16'h0, op_b0 = 16'h0, op_a1 = 16'h0, op_b1 = 16'h0;
  logic        ack0, ack1, done0, done1, err, busy;
  logic [31:0] res;
  logic        m_rst, m_in_rdy;
  logic [15:0] m_a, m_b;
  logic [31:0] m_res = 32'h0;
  logic        m_res_rdy = 1'b0;
  logic        hang = 1'b0;
  int          bm_cnt = 0;

  always #5 clk = ~clk;

  mul_share_ctrl #(.OP_W(16), .RES_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op_a0(op_a0), .op_b0(op_b0), .ack0(ack0), .done0(done0),
    .req1(req1), .op_a1(op_a1), .op_b1(op_b1), .ack1(ack1), .done1(done1),
    .res(res), .err(err), .busy(busy),
    .m_rst(m_rst), .m_a(m_a), .m_b(m_b), .m_in_rdy(m_in_rdy),
    .m_res(m_res), .m_res_rdy(m_res_rdy)
  );

  // bmul model: res_rdy rises after LAT in_rdy cycles and stays high until m_rst.
  always @(posedge clk) begin
    if (m_rst) begin
      m_res_rdy <= 1'b0;
      bm_cnt    <= 0;
    end else if (m_in_rdy && !m_res_rdy && !hang) begin
      if (bm_cnt == LAT - 1) begin
        m_res_rdy <= 1'b1;
        m_res     <= 32'(m_a) * 32'(m_b);
      end else begin
        bm_cnt <= bm_cnt + 1;
      end
    end
  end

  typedef struct {
    int          who;
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int who, input logic [31:0] r, input logic e);
    exp_t x;
    x.who = who;
    x.res = r;
    x.err = e;
    sb_q.push_back(x);
  endtask

  task automatic wait_ack(input string tag, output int who);
    who = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        who = ack1 ? 1 : 0;
        chk({tag, "_ack_onehot"}, {31'd0, ack0 & ack1}, 32'd0);
        break;
      end
    end
    if (who < 0) chk({tag, "_ack_seen"}, 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget,
                           output int who, output int runs, output int stray);
    who = -1; runs = 0; stray = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (m_in_rdy) runs++;
      if (ack0 || ack1) stray++;
      if (done0 || done1) begin
        who = done1 ? 1 : 0;
        break;
      end
    end
    if (who < 0) chk({tag, "_done_seen"}, 32'd0, 32'd1);
  endtask

  task automatic check_done(input string tag, input int who);
    exp_t e;
    chk({tag, "_done_onehot"}, {31'd0, done0 & done1}, 32'd0);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_who"}, who, e.who);
      chk({tag, "_res"}, res, e.res);
      chk({tag, "_err"}, {31'd0, err}, {31'd0, e.err});
    end
  endtask

  // One full transaction with caller-raised requests; optionally re-raises the
  // served requester with fresh operands to keep contention continuous.
  task automatic service(input string tag, input int exp_who, input bit reraise);
    int who, runs, stray;
    push_exp(exp_who, exp_who == 1 ? 32'(op_a1) * 32'(op_b1) : 32'(op_a0) * 32'(op_b0), 1'b0);
    wait_ack(tag, who);
    chk({tag, "_ack_who"}, who, exp_who);
    if (who == 1) req1 = 1'b0;
    else if (who == 0) req0 = 1'b0;
    if (reraise) begin
      @(negedge clk);
      if (who == 1) begin
        op_a1 = 16'($urandom_range(0, 65535)); op_b1 = 16'($urandom_range(0, 65535)); req1 = 1'b1;
      end else begin
        op_a0 = 16'($urandom_range(0, 65535)); op_b0 = 16'($urandom_range(0, 65535)); req0 = 1'b1;
      end
    end
    wait_done(tag, 64, who, runs, stray);
    chk({tag, "_stray_ack"}, stray, 32'd0);
    check_done(tag, who);
  endtask

  initial begin
    int who, runs, stray;

    // ---- reset values
    repeat (2) @(negedge clk);
    chk("rst_ack0", {31'd0, ack0}, 32'd0);
    chk("rst_ack1", {31'd0, ack1}, 32'd0);
    chk("rst_done", {30'd0, done0, done1}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_m_a", {16'd0, m_a}, 32'd0);
    chk("rst_m_b", {16'd0, m_b}, 32'd0);
    chk("rst_m_in_rdy", {31'd0, m_in_rdy}, 32'd0);
    chk("rst_m_rst", {31'd0, m_rst}, 32'd1);
    rst = 1'b0;

    // ---- lone request: 1.5 * 2.0
    @(negedge clk);
    chk("idle_m_rst", {31'd0, m_rst}, 32'd0);
    req0 = 1'b1; op_a0 = 16'h0180; op_b0 = 16'h0200;
    push_exp(0, 32'h0003_0000, 1'b0);
    @(negedge clk);
    chk("lone_ack0", {31'd0, ack0}, 32'd1);
    chk("lone_ack1", {31'd0, ack1}, 32'd0);
    chk("lone_clr_m_rst", {31'd0, m_rst}, 32'd1);
    chk("lone_clr_in_rdy", {31'd0, m_in_rdy}, 32'd0);
    chk("lone_busy", {31'd0, busy}, 32'd1);
    chk("lone_m_a", {16'd0, m_a}, 32'h0180);
    chk("lone_m_b", {16'd0, m_b}, 32'h0200);
    req0 = 1'b0;
    @(negedge clk);
    chk("lone_run_in_rdy", {31'd0, m_in_rdy}, 32'd1);
    chk("lone_run_m_rst", {31'd0, m_rst}, 32'd0);
    chk("lone_run_ack0", {31'd0, ack0}, 32'd0);
    wait_done("lone", 64, who, runs, stray);
    // res_rdy rises after RUN cycle LAT and is seen one cycle later; the first
    // RUN cycle was consumed above.
    chk("lone_runs", runs, LAT);
    check_done("lone", who);
    chk("lone_done_m_rst", {31'd0, m_rst}, 32'd0);
    chk("lone_done_in_rdy", {31'd0, m_in_rdy}, 32'd0);
    @(negedge clk);
    chk("lone_idle_busy", {31'd0, busy}, 32'd0);
    chk("lone_idle_done", {30'd0, done0, done1}, 32'd0);
    chk("lone_res_held", res, 32'h0003_0000);

    // ---- late request from requester 1: 3.0 * 0.25, then 1.0 * 0.5
    req0 = 1'b1; op_a0 = 16'h0300; op_b0 = 16'h0040;
    push_exp(0, 32'h0000_C000, 1'b0);
    wait_ack("late0", who);
    chk("late0_who", who, 32'd0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    req1 = 1'b1; op_a1 = 16'h0100; op_b1 = 16'h0080;
    push_exp(1, 32'h0000_8000, 1'b0);
    wait_done("late0", 64, who, runs, stray);
    chk("late_no_early_ack1", stray, 32'd0);
    check_done("late0", who);
    @(negedge clk);
    chk("late_idle_ack1", {31'd0, ack1}, 32'd0);
    chk("late_idle_busy", {31'd0, busy}, 32'd0);
    chk("stale_res_ignored", res, 32'h0000_C000);
    @(negedge clk);
    chk("late_ack1", {31'd0, ack1}, 32'd1);
    chk("late_clr_res", res, 32'h0000_C000);
    req1 = 1'b0;
    wait_done("late1", 64, who, runs, stray);
    check_done("late1", who);

    // ---- timeout
    hang = 1'b1;
    req0 = 1'b1; op_a0 = 16'h0101; op_b0 = 16'h0202;
    push_exp(0, 32'h0, 1'b1);
    wait_ack("tmo", who);
    chk("tmo_ack_who", who, 32'd0);
    req0 = 1'b0;
    wait_done("tmo", TO + 20, who, runs, stray);
    chk("tmo_runs", runs, TO);
    check_done("tmo", who);
    chk("tmo_done_m_rst", {31'd0, m_rst}, 32'd1);
    chk("tmo_done_in_rdy", {31'd0, m_in_rdy}, 32'd0);
    @(negedge clk);
    chk("tmo_idle_err", {31'd0, err}, 32'd0);
    chk("tmo_idle_m_rst", {31'd0, m_rst}, 32'd0);
    hang = 1'b0;
    req0 = 1'b1; op_a0 = 16'h0280; op_b0 = 16'h0400;
    service("post_tmo", 0, 1'b0);

    // ---- contention after reset
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    op_a0 = 16'($urandom_range(0, 65535)); op_b0 = 16'($urandom_range(0, 65535));
    op_a1 = 16'($urandom_range(0, 65535)); op_b1 = 16'($urandom_range(0, 65535));
    req0 = 1'b1; req1 = 1'b1;
    service("cont_a", 0, 1'b0);
    service("cont_b", 1, 1'b0);
    req0 = 1'b1; req1 = 1'b1;
    service("cont_c", 0, 1'b0);
    service("cont_d", 1, 1'b0);
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      service($sformatf("rr%0d", i), i % 2, i < 4);
    end

    // ---- reset in the third RUN cycle
    hang = 1'b1;
    req0 = 1'b1; op_a0 = 16'h0123; op_b0 = 16'h0456;
    wait_ack("mid", who);
    chk("mid_ack_who", who, 32'd0);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_run3_in_rdy", {31'd0, m_in_rdy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_rdy", {31'd0, m_in_rdy}, 32'd0);
    chk("mid_rst_m_rst", {31'd0, m_rst}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("mid_rst_done", {30'd0, done0, done1}, 32'd0);
    rst = 1'b0;
    hang = 1'b0;
    @(negedge clk);
    chk("mid_after_done", {30'd0, done0, done1}, 32'd0);
    req1 = 1'b1; op_a1 = 16'h0040; op_b1 = 16'h0040;
    service("mid_lone1", 1, 1'b0);
    req0 = 1'b1; req1 = 1'b1;
    op_a0 = 16'h7FFF; op_b0 = 16'hFFFF; op_a1 = 16'hFFFF; op_b1 = 16'hFFFF;
    service("mid_both0", 0, 1'b0);
    service("mid_both1", 1, 1'b0);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case a wait loop is ever bypassed.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
- Sequences one shared `bmul` fixed-point multiplier between two requesters, e.g. two matrix-multiply engines.
- Owns the multiplier's `rst`/`in_rdy` handshake.
- Arbitrates requests round-robin and returns the Q16.16 product to whichever requester won.
- Adds a timeout watchdog so a hung multiplier cannot stall both requesters.

Parameters:
- OP_W, 16, operand width (Q8.8: [15:8] integer, [7:0] fraction)
- RES_W, 32, product width (Q16.16, {res_int1,res_int2,res_dec1,res_dec2})
- TIMEOUT, 64, max RUN cycles waiting for m_res_rdy before abort (>=2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req0  in  1  requester 0 request; held high until ack0
- op_a0  in  OP_W  requester 0 operand A
- op_b0  in  OP_W  requester 0 operand B
- ack0  out  1  one-cycle pulse: req0 operands captured
- done0  out  1  one-cycle pulse: res valid for requester 0
- req1, op_a1, op_b1, ack1, done1  same as above, for requester 1
- res  out  RES_W  last product; held until next DONE
- err  out  1  high with doneN when the operation timed out
- busy  out  1  high in every state except IDLE
- m_rst  out  1  to bmul rst
- m_a  out  OP_W  to bmul; [15:8] drives a_int, [7:0] drives a_dec
- m_b  out  OP_W  to bmul; [15:8] drives b_int, [7:0] drives b_dec
- m_in_rdy  out  1  to bmul in_rdy
- m_res  in  RES_W  from bmul result fields
- m_res_rdy  in  1  from bmul res_rdy

Behaviour:
- All outputs are registered.
- Reset values: ack0/1=0, done0/1=0, err=0, busy=0, res=0, m_a=0, m_b=0, m_in_rdy=0, m_rst=1. Last-grant pointer = 1, so requester 0 has priority first. State = IDLE. Timeout counter = 0.
- States and transitions:
  - IDLE: m_rst=0, m_in_rdy=0. If any req is high at the clock edge, pick the winner and latch its operands into m_a/m_b. Round-robin rule: the requester not granted last wins; a lone requester wins outright. Go to CLR. Otherwise stay in IDLE.
  - CLR (1 cycle): ack of the winner = 1, m_rst=1 (clears stale bmul res_rdy), m_in_rdy=0, counter cleared. Go to RUN.
  - RUN: m_rst=0, m_in_rdy=1, m_a/m_b held stable, counter increments each cycle.
    - If m_res_rdy=1: capture m_res into res, set err=0, go to DONE.
    - Else if counter reaches TIMEOUT-1: set res=0, err=1, go to DONE.
  - DONE (1 cycle): done of the winner = 1, m_in_rdy=0. If err=1, m_rst=1 to abort the multiplier. Update the last-grant pointer to the winner. Go to IDLE.
- Latency:
  - req sampled at edge t -> ack during cycle t+1 -> m_in_rdy high from cycle t+2.
  - m_res_rdy sampled at edge e -> done/res valid during cycle e+1 -> IDLE at e+2.
  - Minimum issue-to-issue interval = 4 + bmul latency.
- Requests:
  - req is sampled only in IDLE. Requester holds req and operands until ack, then drops req.
  - A req high while busy is neither acked nor lost; it is granted at the next IDLE.
  - A req dropped before ack has no effect.
- Simultaneous req0 and req1: round-robin, strict alternation under continuous contention.
- err is meaningful only while a doneN is high; it is cleared in the next IDLE.
- res keeps its value after DONE until the next DONE.
- m_res_rdy outside RUN is ignored.
- Reset mid-operation (any state): immediate return to reset values. m_in_rdy drops asynchronously, m_rst=1. No ack or done is emitted. The pointer returns to its reset value.
- No arithmetic is performed here; m_res passes through unmodified.

Decomposition:
- Shared package `mmul_pkg` holds:
  - Q8.8 and Q16.16 width constants (OP_W=16, RES_W=32)
  - state encoding localparams IDLE/CLR/RUN/DONE
  - TIMEOUT default
- One natural sub-module: `rr_arb2`, a 2-way round-robin picker. Inputs: req[1:0], last pointer. Outputs: one-hot grant. Combinational, instantiated once.

Test Plan:
- Lone request: req0=1, op_a0=0x0180 (1.5), op_b0=0x0200 (2.0), bmul model with 5-cycle latency -> ack0 one cycle later, m_in_rdy high the cycle after that, done0 pulse with res=0x00030000, err=0, done1 never asserted.
- Contention after reset: req0 and req1 both high -> requester 0 served first, then requester 1. Repeat with both high -> requester 0 first again (pointer now 1). Three back-to-back rounds alternate 0,1,0,1,0,1.
- Late request: req1 rises two cycles after ack0 -> no ack1 until the cycle after done0 + IDLE. op_a1=0x0100, op_b1=0x0080 -> res=0x00008000.
- Timeout: bmul stub never raises m_res_rdy -> exactly TIMEOUT RUN cycles, then done0=1, err=1, res=0, m_rst=1 in the DONE cycle. Next request completes normally with err=0.
- Reset mid-RUN: assert rst on the 3rd RUN cycle -> m_in_rdy=0 and m_rst=1 immediately, no done0. After release, req1 alone is served, and the first simultaneous request goes to requester 0.
- Stale result: m_res_rdy held high from the previous op into IDLE/CLR -> ignored. The CLR m_rst pulse clears it, and res updates only after the new RUN.
